// File: rtl/reg_file_8x16.sv
// reg_file_8x16
// ---------------------------------------------------------------------------
// Eight-entry register file with one write port and two registered read ports.
// The write port takes the one-hot output of the upstream 3-to-8 address
// decoder directly as per-register write enables. A select with two or more
// bits set is treated as illegal: the whole write is dropped and a sticky
// error flag is raised until cleared.
//
// Parameters
//   WIDTH   data width of every register and of d/qa/qb
//   BYPASS  1: a read of the register being written on the same edge returns
//              the new data; 0: it returns the pre-write contents
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears storage, qa, qb, sel_err)
//   we_sel   in   [7:0] one-hot write select, all-zero = no write
//   d        in   [WIDTH-1:0] write data
//   ra, rb   in   [2:0] binary read addresses for ports A and B
//   qa, qb   out  [WIDTH-1:0] read data, one cycle after the address
//   clr_err  in   synchronous clear of sel_err (an illegal select on the
//                 same edge takes priority)
//   sel_err  out  sticky illegal-select flag
// ---------------------------------------------------------------------------
module reg_file_8x16 #(
  parameter int WIDTH  = 16,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       we_sel,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       ra,
  input  logic [2:0]       rb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic             clr_err,
  output logic             sel_err
);

  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             sel_err_q, sel_err_d;

  logic [3:0]       sel_cnt;
  logic             sel_legal;

  // Population count of the select; zero or one bit set is a legal write.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      sel_cnt = sel_cnt + {3'b000, we_sel[i]};
    end
    sel_legal = (sel_cnt <= 4'd1);
  end

  // Next-state storage: an illegal select gates off every enable so no
  // register is touched.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = (we_sel[i] && sel_legal) ? d : mem_q[i];
    end
  end

  // mem_d already carries the forwarded value for a legal write, and the
  // stored value otherwise, so reading it implements write-to-read bypass
  // without forwarding suppressed writes.
  always_comb begin
    qa_d = mem_q[ra];
    qb_d = mem_q[rb];
    if (BYPASS != 0) begin
      qa_d = mem_d[ra];
      qb_d = mem_d[rb];
    end
  end

  // Set has priority over clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (!sel_legal) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= '0;
      end
      qa_q      <= '0;
      qb_q      <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
      qa_q      <= qa_d;
      qb_q      <= qb_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign qa      = qa_q;
  assign qb      = qb_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// Testbench for reg_file_8x16: one instance with forwarding, one without,
// driven by shared inputs and compared against an array-based reference.
module tb_reg_file_8x16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   we_sel = '0;
  logic [W-1:0] d = '0;
  logic [2:0]   ra = '0;
  logic [2:0]   rb = '0;
  logic         clr_err = 1'b0;

  logic [W-1:0] qa1, qb1, qa0, qb0;
  logic         err1, err0;

  int checks = 0;
  int failures = 0;

  // Reference state: contents of the eight registers and the error flag.
  logic [W-1:0] model [8];
  logic         err_m;

  always #5 clk = ~clk;

  reg_file_8x16 #(.WIDTH(W), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we_sel(we_sel), .d(d), .ra(ra), .rb(rb),
    .qa(qa1), .qb(qb1), .clr_err(clr_err), .sel_err(err1)
  );

  reg_file_8x16 #(.WIDTH(W), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .we_sel(we_sel), .d(d), .ra(ra), .rb(rb),
    .qa(qa0), .qb(qb0), .clr_err(clr_err), .sel_err(err0)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
    err_m = 1'b0;
  endtask

  // One clock cycle with the inputs currently applied; predicts both
  // instances' outputs from the reference, then compares after the edge.
  task automatic cyc(input string tag);
    logic [W-1:0] e_a1, e_b1, e_a0, e_b0;
    logic         legal, wr, e_err;
    legal = ($countones(we_sel) <= 1);
    wr    = legal && (we_sel != 8'h00);
    e_a0  = model[ra];
    e_b0  = model[rb];
    e_a1  = (wr && we_sel[ra]) ? d : model[ra];
    e_b1  = (wr && we_sel[rb]) ? d : model[rb];
    if (!legal)       e_err = 1'b1;
    else if (clr_err) e_err = 1'b0;
    else              e_err = err_m;
    @(posedge clk);
    if (wr) begin
      for (int i = 0; i < 8; i++) if (we_sel[i]) model[i] = d;
    end
    err_m = e_err;
    #1;
    chk({tag, ".qa_byp"}, qa1, e_a1);
    chk({tag, ".qb_byp"}, qb1, e_b1);
    chk({tag, ".qa_nobyp"}, qa0, e_a0);
    chk({tag, ".qb_nobyp"}, qb0, e_b0);
    chk({tag, ".err_byp"}, {15'd0, err1}, {15'd0, e_err});
    chk({tag, ".err_nobyp"}, {15'd0, err0}, {15'd0, e_err});
  endtask

  task automatic idle();
    we_sel = 8'h00;
    clr_err = 1'b0;
  endtask

  initial begin
    model_clear();

    // Reset at start, released between edges.
    #1 reset = 1'b0;
    #2;
    chk("rst.qa", qa1, '0);
    chk("rst.qb", qb1, '0);
    chk("rst.err", {15'd0, err1}, 16'd0);
    #4 reset = 1'b1;

    // 1: read everything after reset, then a single write to register 3.
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      rb = 3'(7 - i);
      cyc("t1.rd0");
    end
    we_sel = 8'h08; d = 16'hA5A5; ra = 3'd0; rb = 3'd1;
    cyc("t1.wr");
    idle(); ra = 3'd3; rb = 3'd2;
    cyc("t1.rd3");
    chk("t1.qa_is_a5a5", qa1, 16'hA5A5);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'((i + 4) % 8);
      cyc("t1.rdall");
    end

    // 2: distinct value in every register, then read in pairs.
    for (int i = 0; i < 8; i++) begin
      we_sel = 8'(1 << i);
      d = 16'h1111 * 16'(i + 1);
      ra = 3'((i + 1) % 8); rb = 3'((i + 5) % 8);
      cyc("t2.wr");
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'((i + 3) % 8);
      cyc("t2.rd");
    end
    ra = 3'd6; rb = 3'd1;
    cyc("t2.rd61");
    chk("t2.qa_is_7777", qa1, 16'h7777);
    chk("t2.qb_is_2222", qb1, 16'h2222);

    // 3: read-during-write on register 5 from both ports.
    we_sel = 8'h20; d = 16'h1234; ra = 3'd0; rb = 3'd0;
    cyc("t3.pre");
    we_sel = 8'h20; d = 16'hBEEF; ra = 3'd5; rb = 3'd5;
    cyc("t3.rdw");
    chk("t3.byp_new", qa1, 16'hBEEF);
    chk("t3.nobyp_old", qb0, 16'h1234);
    idle();
    cyc("t3.after");
    chk("t3.nobyp_new", qa0, 16'hBEEF);

    // 4: illegal select, sticky flag, clear, and set-beats-clear.
    we_sel = 8'h41; d = 16'hFFFF; ra = 3'd0; rb = 3'd6;
    cyc("t4.ill");
    chk("t4.err_set", {15'd0, err1}, 16'd1);
    idle();
    for (int i = 0; i < 3; i++) cyc("t4.hold");
    chk("t4.r0_kept", qa1, 16'h1111);
    chk("t4.r6_kept", qb1, 16'h7777);
    clr_err = 1'b1;
    cyc("t4.clr");
    chk("t4.err_clr", {15'd0, err1}, 16'd0);
    we_sel = 8'hC0; clr_err = 1'b1; d = 16'h0F0F;
    cyc("t4.setclr");
    chk("t4.set_wins", {15'd0, err0}, 16'd1);
    idle(); ra = 3'd7; rb = 3'd6;
    cyc("t4.nowrite");
    clr_err = 1'b1;
    cyc("t4.clr2");

    // 5: asynchronous reset between edges while a write is pending.
    we_sel = 8'h04; d = 16'h7777; ra = 3'd2; rb = 3'd2;
    cyc("t5.wr");
    chk("t5.r2_7777", qa1, 16'h7777);
    we_sel = 8'h04; d = 16'h9999;
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("t5.async_qa", qa1, '0);
    chk("t5.async_qb", qb0, '0);
    chk("t5.async_err", {15'd0, err1}, 16'd0);
    #2 reset = 1'b1;
    idle();
    cyc("t5.rd2");
    chk("t5.r2_zero", qa1, 16'h0000);

    // 6: idle select with random data leaves everything alone.
    for (int i = 0; i < 8; i++) begin
      we_sel = 8'(1 << i); d = 16'($urandom);
      cyc("t6.fill");
    end
    for (int i = 0; i < 10; i++) begin
      we_sel = 8'h00; d = 16'($urandom);
      ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7));
      cyc("t6.idle");
    end

    // Randomised traffic: mostly one-hot writes, some idle and some illegal.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      we_sel = 8'(1 << $urandom_range(0, 7));
      else if (kind < 8) we_sel = 8'h00;
      else               we_sel = 8'($urandom);
      d = 16'($urandom);
      ra = 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
      clr_err = ($urandom_range(0, 4) == 0);
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
